// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Types and constants shared by the instruction memory, its
//                fetch path and the instruction memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    localparam int INSTR_W     = 24;
    localparam int IMEM_ADDR_W = 8;

    typedef logic [INSTR_W-1:0] instr_t;

    // Loader FSM: three byte-collect states, one write state, one done state.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        B0    = 3'd1,
        B1    = 3'd2,
        B2    = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loader_if
//  Description : Byte stream, control and memory write port bundle of the
//                instruction memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_loader_if #(
    parameter int ADDR_W = 8
);
    import imem_pkg::*;

    logic              start;
    logic [ADDR_W:0]   num_words;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    instr_t            wr_data;
    logic              pc_hold;
    logic              done;
    logic [7:0]        checksum;

    // Master: the byte source / controller side.
    modport master (
        output start, num_words, byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data, pc_hold, done, checksum
    );

    // Slave: the loader itself.
    modport slave (
        input  start, num_words, byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data, pc_hold, done, checksum
    );

endinterface
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loader
//  Description : Packs a byte stream (MSB first) into 24-bit instruction
//                words and writes them to consecutive instruction memory
//                addresses from 0, holding the PC in reset while loading.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              CLK,
    input  logic              reset,
    instr_mem_loader_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE_CNT   = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_t     r_state;
    loader_state_t     w_next;

    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_addr;
    instr_t            r_word;
    logic [7:0]        r_checksum;

    logic              w_accept_start;
    logic              w_xfer;
    logic              w_last;
    logic [ADDR_W:0]   w_count_clamped;

    assign w_accept_start  = (r_state == IDLE) && bus.start;
    assign w_xfer          = bus.byte_valid && bus.byte_ready;
    // Address is widened by one bit so a full DEPTH-word load compares cleanly.
    assign w_last          = ({1'b0, r_addr} == (r_count - ONE_CNT));
    assign w_count_clamped = (bus.num_words > DEPTH_CNT) ? DEPTH_CNT : bus.num_words;

    // All outputs come from registers or the state decode, never from byte_valid.
    assign bus.byte_ready = (r_state == B0) || (r_state == B1) || (r_state == B2);
    assign bus.wr_en      = (r_state == WRITE);
    assign bus.wr_addr    = r_addr;
    assign bus.wr_data    = r_word;
    assign bus.pc_hold    = (r_state != IDLE);
    assign bus.done       = (r_state == DONE);
    assign bus.checksum   = r_checksum;

    // State register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept_start) begin
                    w_next = (w_count_clamped == '0) ? DONE : B0;
                end
            end
            B0:      if (w_xfer) w_next = B1;
            B1:      if (w_xfer) w_next = B2;
            B2:      if (w_xfer) w_next = WRITE;
            WRITE:   w_next = w_last ? DONE : B0;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Count latch, byte packer, running checksum and address counter.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_addr     <= '0;
            r_word     <= '0;
            r_checksum <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept_start) begin
                        r_count    <= w_count_clamped;
                        r_addr     <= '0;
                        r_checksum <= '0;
                    end
                end
                B0: begin
                    if (w_xfer) begin
                        r_word[23:16] <= bus.byte_in;
                        r_checksum    <= r_checksum ^ bus.byte_in;
                    end
                end
                B1: begin
                    if (w_xfer) begin
                        r_word[15:8] <= bus.byte_in;
                        r_checksum   <= r_checksum ^ bus.byte_in;
                    end
                end
                B2: begin
                    if (w_xfer) begin
                        r_word[7:0] <= bus.byte_in;
                        r_checksum  <= r_checksum ^ bus.byte_in;
                    end
                end
                WRITE: begin
                    // The final address is left on wr_addr once the load ends.
                    if (!w_last) begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_loader
//  Description : Self-checking bench for instr_mem_loader with a word-level
//                reference model and randomized byte-valid patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_mem_loader_if #(.ADDR_W(8)) bus ();

    instr_mem_loader #(.ADDR_W(8), .DEPTH(256)) dut (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: counts bytes and words instead of tracking states.
    logic [7:0] m_bytes [0:767];
    int         m_got   = 0;
    int         m_total = 0;
    logic       m_busy  = 1'b0;
    logic       m_wr    = 1'b0;
    logic       m_done  = 1'b0;
    logic [7:0] m_chk   = 8'h00;

    logic [31:0] wlog [$];
    int          done_cnt = 0;
    logic [7:0]  img [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: a word is written after every third accepted byte,
    // done follows the write of the last word (or the start of an empty load).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_wr <= 1'b0; m_done <= 1'b0;
            m_chk  <= 8'h00; m_got <= 0; m_total <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_wr) begin
            m_wr <= 1'b0;
            if (m_got / 3 >= m_total) m_done <= 1'b1;
        end else if (m_busy) begin
            if (bus.byte_valid) begin
                m_bytes[m_got] <= bus.byte_in;
                m_chk          <= m_chk ^ bus.byte_in;
                m_got          <= m_got + 1;
                if ((m_got + 1) % 3 == 0) m_wr <= 1'b1;
            end
        end else if (bus.start) begin
            m_total <= (int'(bus.num_words) > 256) ? 256 : int'(bus.num_words);
            m_got   <= 0;
            m_chk   <= 8'h00;
            m_busy  <= 1'b1;
            if (bus.num_words == 9'd0) m_done <= 1'b1;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        check("pc_hold",    32'(bus.pc_hold),    32'(m_busy));
        check("byte_ready", 32'(bus.byte_ready), 32'(m_busy && !m_wr && !m_done));
        check("wr_en",      32'(bus.wr_en),      32'(m_wr));
        check("done",       32'(bus.done),       32'(m_done));
        check("checksum",   32'(bus.checksum),   32'(m_chk));
        if (m_wr && m_got >= 3) begin
            check("wr_addr", 32'(bus.wr_addr), 32'(m_got / 3 - 1));
            check("wr_data", 32'(bus.wr_data),
                  32'({m_bytes[m_got-3], m_bytes[m_got-2], m_bytes[m_got-1]}));
        end
        if (bus.wr_en) wlog.push_back({bus.wr_addr, bus.wr_data});
        if (bus.done)  done_cnt++;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
        check({tag, "_wr_en"},      32'(bus.wr_en),      32'd0);
        check({tag, "_wr_addr"},    32'(bus.wr_addr),    32'd0);
        check({tag, "_wr_data"},    32'(bus.wr_data),    32'd0);
        check({tag, "_pc_hold"},    32'(bus.pc_hold),    32'd0);
        check({tag, "_done"},       32'(bus.done),       32'd0);
        check({tag, "_checksum"},   32'(bus.checksum),   32'd0);
    endtask

    // mode 0: valid always high, 1: toggles every cycle, 2: random.
    // abort_at >= 0 stops driving once that many bytes have transferred.
    task automatic run_load(input int n, input int mode, input bit glitch, input int abort_at);
        int  idx = 0;
        int  cyc = 0;
        int  nbytes;
        bit  saw_done = 1'b0;
        bit  glitched = 1'b0;
        bit  v;
        nbytes = 3 * ((n > 256) ? 256 : n);
        @(negedge clk);
        wlog.delete();
        done_cnt = 0;
        bus.start     = 1'b1;
        bus.num_words = 9'(n);
        while (!saw_done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (bus.done) saw_done = 1'b1;
            if (abort_at >= 0 && idx == abort_at) break;
            if (glitch && idx == 1 && !glitched) begin
                bus.start     = 1'b1;
                bus.num_words = 9'd7;
                glitched      = 1'b1;
            end
            if (idx < nbytes) begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = cyc[0];
                    default: v = 1'($urandom_range(0, 1));
                endcase
                bus.byte_in = img[idx];
            end else begin
                v = 1'b0;
                bus.byte_in = 8'($urandom);
            end
            bus.byte_valid = v;
            if (v && bus.byte_ready) idx++;
        end
        bus.byte_valid = 1'b0;
        bus.start      = 1'b0;
        if (abort_at < 0) check("load_completes", 32'(saw_done), 32'd1);
        #1;
    endtask

    initial begin
        bus.start = 1'b0; bus.num_words = '0; bus.byte_in = 8'h00; bus.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;

        // Six-byte image, gap-free, then with toggling valid.
        img = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        for (int pass = 0; pass < 2; pass++) begin
            run_load(2, pass, 1'b0, -1);
            check("img_nwrites", 32'(wlog.size()), 32'd2);
            if (wlog.size() == 2) begin
                check("img_w0", wlog[0], 32'h00123456);
                check("img_w1", wlog[1], 32'h01ABCDEF);
            end
            check("img_done_cnt", 32'(done_cnt), 32'd1);
            check("img_checksum", 32'(bus.checksum), 32'h000000F9);
            check("img_model_chk", 32'(m_chk), 32'h000000F9);
        end

        // Empty load.
        run_load(0, 0, 1'b0, -1);
        check("zero_nwrites", 32'(wlog.size()), 32'd0);
        check("zero_done_cnt", 32'(done_cnt), 32'd1);
        check("zero_checksum", 32'(bus.checksum), 32'd0);

        // Full-depth ramp.
        img.delete();
        for (int i = 0; i < 768; i++) img.push_back(8'(i));
        run_load(256, 0, 1'b0, -1);
        check("ramp_nwrites", 32'(wlog.size()), 32'd256);
        if (wlog.size() == 256) begin
            check("ramp_first", wlog[0],   32'h00000102);
            check("ramp_last",  wlog[255], 32'hFFFDFEFF);
        end
        check("ramp_done_cnt", 32'(done_cnt), 32'd1);

        // Oversized count clamps to the full depth.
        img.delete();
        for (int i = 0; i < 768; i++) img.push_back(8'($urandom));
        run_load(300, 2, 1'b0, -1);
        check("clamp_nwrites", 32'(wlog.size()), 32'd256);
        if (wlog.size() == 256) check("clamp_last_addr", 32'(wlog[255][31:24]), 32'hFF);

        // Second start while in B1 is ignored.
        img = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        run_load(2, 0, 1'b1, -1);
        check("glitch_nwrites", 32'(wlog.size()), 32'd2);
        check("glitch_done_cnt", 32'(done_cnt), 32'd1);

        // Reset while collecting word 1 (in B2).
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        run_load(3, 0, 1'b0, 5);
        check("abort_pre_writes", 32'(wlog.size()), 32'd1);
        check("abort_in_b2_ready", 32'(bus.byte_ready), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_vals("async");
        @(negedge clk);
        check("abort_no_write", 32'(wlog.size()), 32'd1);
        rst = 1'b0;
        run_load(3, 1, 1'b0, -1);
        check("reload_nwrites", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            check("reload_w0", wlog[0], 32'h00010203);
            check("reload_w2", wlog[2], 32'h02070809);
        end

        // Randomized loads.
        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(0, 6);
            img.delete();
            for (int i = 0; i < 3 * n; i++) img.push_back(8'($urandom));
            run_load(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
            check("rand_nwrites", 32'(wlog.size()), 32'(n));
            check("rand_done_cnt", 32'(done_cnt), 32'd1);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
